instr_decode_alu: RTL and testbench

- Combined instruction decoder and ALU for the 16-bit single-cycle datapath.
- Splits a 16-bit instruction into opcode and register/immediate fields combinationally, so the surrounding datapath can address the register file.
- Computes a data result and a memory/jump/branch address from the operands, and registers both at the clock edge.
- Sits between the instruction register / register file and the data memory / PC-update logic.

---
 rtl/instr_decode_alu.sv | 212 +++++++++++++++++++++
 tb/tb_instr_decode_alu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_alu.sv
// ============================================================================
// instr_decode_alu
// ----------------------------------------------------------------------------
// Combined instruction decoder and ALU for the 16-bit single-cycle datapath.
// The instruction fields are decoded combinationally so the register file can
// be addressed in the same cycle. The data result (d) and the memory/jump/
// branch address (daddr) are registered on the rising edge of clk.
//
// Parameters:
//   DATA_W    operand/result width (instruction format is always 16 bits)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   in_valid   in   instr/a/b/pc valid this cycle
//   instr      in   16-bit instruction word
//   a, b       in   operands from register op1 / op2
//   pc         in   4-bit current instruction index
//   opcode     out  instr[15:12]                      (combinational)
//   op1        out  instr[11:9]                       (combinational)
//   op2        out  R-type instr[8:6], otherwise 0    (combinational)
//   dest       out  R-type instr[5:3], else instr[8:6](combinational)
//   shamt      out  instr[2:0]                        (combinational)
//   imm        out  instr[5:0]                        (combinational)
//   jaddr      out  instr[8:0]                        (combinational)
//   d          out  registered ALU result
//   daddr      out  registered 16-bit address result
//   out_valid  out  registered copy of in_valid
//
// Optional build macro ALU_FLAGS_EN adds registered flags:
//   zero       out  d == 0
//   ovf        out  signed overflow for ADD/SUB/ADDI, 0 otherwise
// ============================================================================
module instr_decode_alu #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        pc,
    output logic [3:0]        opcode,
    output logic [2:0]        op1,
    output logic [2:0]        op2,
    output logic [2:0]        dest,
    output logic [2:0]        shamt,
    output logic [5:0]        imm,
    output logic [8:0]        jaddr,
    output logic [DATA_W-1:0] d,
    output logic [15:0]       daddr,
    output logic              out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic              zero,
    output logic              ovf
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_SLT  = 4'h4, OP_ADDI = 4'h5, OP_LI = 4'h6, OP_LW  = 4'h7,
        OP_SW   = 4'h8, OP_J   = 4'h9, OP_SLL = 4'hA, OP_SRL = 4'hB,
        OP_SRA  = 4'hC, OP_ROL = 4'hD, OP_BEQ = 4'hE, OP_BNE = 4'hF
    } opcode_e;

    localparam int MSB = DATA_W - 1;

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic    w_rtype;
    opcode_e w_op;

    assign opcode = instr[15:12];
    assign op1    = instr[11:9];
    assign shamt  = instr[2:0];
    assign imm    = instr[5:0];
    assign jaddr  = instr[8:0];
    assign w_op   = opcode_e'(instr[15:12]);

    // R-type occupies 0000-0100 and 1010-1101; everything else carries an
    // immediate/jump field where op2 would sit, so dest moves up to [8:6].
    assign w_rtype = (instr[15:12] <= 4'd4) ||
                     ((instr[15:12] >= 4'd10) && (instr[15:12] <= 4'd13));
    assign op2     = w_rtype ? instr[8:6] : 3'd0;
    assign dest    = w_rtype ? instr[5:3] : instr[8:6];

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    w_imm_sext;
    logic [DATA_W-1:0]    w_imm_zext;
    logic [DATA_W-1:0]    w_sum;
    logic [DATA_W-1:0]    w_diff;
    logic [DATA_W-1:0]    w_addi;
    logic [DATA_W+15:0]   w_addr_wide;
    logic [15:0]          w_mem_addr;
    logic [DATA_W-1:0]    w_sra;
    logic [DATA_W-1:0]    w_rol;
    logic [31:0]          w_rol_rsh;
    logic [DATA_W-1:0]    w_d;
    logic [15:0]          w_daddr;

    assign w_imm_sext = {{(DATA_W-6){imm[5]}}, imm};
    assign w_imm_zext = DATA_W'(imm);
    assign w_sum      = a + b;
    assign w_diff     = a - b;
    assign w_addi     = a + w_imm_sext;

    // Pad with zeros above the sum so the low 16 bits are a truncation when
    // DATA_W > 16 and a zero-extension when DATA_W < 16.
    assign w_addr_wide = {16'd0, w_addi};
    assign w_mem_addr  = w_addr_wide[15:0];

    assign w_sra     = $unsigned($signed(a) >>> shamt);
    // A shift by DATA_W yields 0, so shamt==0 falls out as a plain copy of a.
    assign w_rol_rsh = 32'(DATA_W) - 32'(shamt);
    assign w_rol     = (a << shamt) | (a >> w_rol_rsh);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_d     = '0;
        w_daddr = '0;
        case (w_op)
            OP_ADD:  w_d = w_sum;
            OP_SUB:  w_d = w_diff;
            OP_AND:  w_d = a & b;
            OP_OR:   w_d = a | b;
            OP_SLT:  w_d = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            OP_ADDI: w_d = w_addi;
            OP_LI:   w_d = w_imm_zext;
            OP_LW,
            OP_SW:   w_daddr = w_mem_addr;
            OP_J:    w_daddr = 16'(pc) + 16'(jaddr);
            OP_SLL:  w_d = a << shamt;
            OP_SRL:  w_d = a >> shamt;
            OP_SRA:  w_d = w_sra;
            OP_ROL:  w_d = w_rol;
            OP_BEQ,
            OP_BNE:  w_daddr = 16'(imm);
            default: begin
                w_d     = '0;
                w_daddr = '0;
            end
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic w_ovf;

    // Signed overflow: operands of the same sign (for SUB, opposite signs)
    // producing a result whose sign differs from a.
    always_comb begin
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD:  w_ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            OP_SUB:  w_ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            OP_ADDI: w_ovf = (a[MSB] == w_imm_sext[MSB]) && (w_addi[MSB] != a[MSB]);
            default: w_ovf = 1'b0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Output registers: results hold when in_valid is low, out_valid drops.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_d;
    logic [15:0]       r_daddr;
    logic              r_out_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d         <= '0;
            r_daddr     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_d     <= w_d;
                r_daddr <= w_daddr;
            end
        end
    end

    assign d         = r_d;
    assign daddr     = r_daddr;
    assign out_valid = r_out_valid;

`ifdef ALU_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (in_valid) begin
            r_zero <= (w_d == '0);
            r_ovf  <= w_ovf;
        end
    end

    assign zero = r_zero;
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_instr_decode_alu.sv
// ============================================================================
// tb_instr_decode_alu
// ----------------------------------------------------------------------------
// Directed vectors with hand-computed results. The stimulus process pushes
// the expected registered response into a queue; a monitor process pops and
// compares whenever out_valid is high. Decoded fields, reset and hold
// behaviour are checked directly by the stimulus process.
// ============================================================================
module tb_instr_decode_alu;

    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [15:0]       instr;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        pc;
    logic [3:0]        opcode;
    logic [2:0]        op1;
    logic [2:0]        op2;
    logic [2:0]        dest;
    logic [2:0]        shamt;
    logic [5:0]        imm;
    logic [8:0]        jaddr;
    logic [DATA_W-1:0] d;
    logic [15:0]       daddr;
    logic              out_valid;
`ifdef ALU_FLAGS_EN
    logic              zero;
    logic              ovf;
`endif

    instr_decode_alu #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .instr     (instr),
        .a         (a),
        .b         (b),
        .pc        (pc),
        .opcode    (opcode),
        .op1       (op1),
        .op2       (op2),
        .dest      (dest),
        .shamt     (shamt),
        .imm       (imm),
        .jaddr     (jaddr),
        .d         (d),
        .daddr     (daddr),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  pc;
        logic [15:0] d;
        logic [15:0] daddr;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] daddr;
        logic        zero;
        logic        ovf;
    } exp_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one transaction, optionally queueing its expected result.
    task automatic drive(input vec_t v, input bit push);
        exp_t e;
        instr    = v.instr;
        a        = v.a;
        b        = v.b;
        pc       = v.pc;
        in_valid = 1'b1;
        if (push) begin
            e.d     = v.d;
            e.daddr = v.daddr;
            e.zero  = (v.d == 16'd0);
            e.ovf   = v.ovf;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare registered results on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got d=%0h daddr=%0h, expected no output", d, daddr);
                end else begin
                    e = exp_q.pop_front();
                    check("d", 32'(d), 32'(e.d));
                    check("daddr", 32'(daddr), 32'(e.daddr));
`ifdef ALU_FLAGS_EN
                    check("zero", 32'(zero), 32'(e.zero));
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vr;
        vecs = '{
            //  instr     a         b         pc    d         daddr     ovf
            '{16'h0298, 16'h0005, 16'h0007, 4'd0, 16'h000C, 16'h0000, 1'b0}, // ADD
            '{16'h52BF, 16'h000A, 16'h0000, 4'd0, 16'h0009, 16'h0000, 1'b0}, // ADDI -1
            '{16'h7704, 16'h0002, 16'h0000, 4'd0, 16'h0000, 16'h0006, 1'b0}, // LW
            '{16'h9005, 16'h0000, 16'h0000, 4'd3, 16'h0000, 16'h0008, 1'b0}, // J
            '{16'hC213, 16'h8010, 16'h0000, 4'd0, 16'hF002, 16'h0000, 1'b0}, // SRA 3
            '{16'h4000, 16'hFFFF, 16'h0001, 4'd0, 16'h0001, 16'h0000, 1'b0}, // SLT -1<1
            '{16'h4000, 16'h0001, 16'hFFFF, 4'd0, 16'h0000, 16'h0000, 1'b0}, // SLT 1<-1
            '{16'h1000, 16'h1234, 16'h1234, 4'd0, 16'h0000, 16'h0000, 1'b0}, // SUB equal
            '{16'h0000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 16'h0000, 1'b1}, // ADD ovf
            '{16'h0000, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 16'h0000, 1'b0}, // ADD wrap
            '{16'hA000, 16'hABCD, 16'h0000, 4'd0, 16'hABCD, 16'h0000, 1'b0}, // SLL 0
            '{16'hA004, 16'h1234, 16'h0000, 4'd0, 16'h2340, 16'h0000, 1'b0}, // SLL 4
            '{16'hB004, 16'h8010, 16'h0000, 4'd0, 16'h0801, 16'h0000, 1'b0}, // SRL 4
            '{16'hD004, 16'h1234, 16'h0000, 4'd0, 16'h2341, 16'h0000, 1'b0}, // ROL 4
            '{16'hD001, 16'h8001, 16'h0000, 4'd0, 16'h0003, 16'h0000, 1'b0}, // ROL 1
            '{16'h2000, 16'hF0F0, 16'hFF00, 4'd0, 16'hF000, 16'h0000, 1'b0}, // AND
            '{16'h3000, 16'hF0F0, 16'hFF00, 4'd0, 16'hFFF0, 16'h0000, 1'b0}, // OR
            '{16'h603F, 16'h1234, 16'h0000, 4'd0, 16'h003F, 16'h0000, 1'b0}, // LI
            '{16'h8E3E, 16'h0010, 16'h0000, 4'd0, 16'h0000, 16'h000E, 1'b0}, // SW -2
            '{16'hE02A, 16'h5555, 16'h0000, 4'd0, 16'h0000, 16'h002A, 1'b0}, // BEQ
            '{16'hF015, 16'h0000, 16'h0000, 4'd7, 16'h0000, 16'h0015, 1'b0}, // BNE
            '{16'h1000, 16'h8000, 16'h0001, 4'd0, 16'h7FFF, 16'h0000, 1'b1}, // SUB ovf
            '{16'h5001, 16'h7FFF, 16'h0000, 4'd0, 16'h8000, 16'h0000, 1'b1}  // ADDI ovf
        };

        reset    = 1'b0;
        in_valid = 1'b0;
        instr    = 16'h0000;
        a        = '0;
        b        = '0;
        pc       = 4'd0;

        #2;
        check("reset_d", 32'(d), 32'h0);
        check("reset_daddr", 32'(daddr), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        #10 reset = 1'b1;

        // Back-to-back directed vectors.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i], 1'b1);
            #1;
            if (i == 0) begin
                check("add_opcode", 32'(opcode), 32'h0);
                check("add_op1", 32'(op1), 32'd1);
                check("add_op2", 32'(op2), 32'd2);
                check("add_dest", 32'(dest), 32'd3);
            end
            if (i == 1) begin
                check("addi_op1", 32'(op1), 32'd1);
                check("addi_op2", 32'(op2), 32'd0);
                check("addi_dest", 32'(dest), 32'd2);
                check("addi_imm", 32'(imm), 32'h3F);
            end
            if (i == 3) begin
                check("j_opcode", 32'(opcode), 32'h9);
                check("j_jaddr", 32'(jaddr), 32'h5);
            end
            if (i == 4) begin
                check("sra_shamt", 32'(shamt), 32'd3);
                check("sra_dest", 32'(dest), 32'd2);
                check("sra_op2", 32'(op2), 32'd0);
            end
        end

        // Last vector captured here; then two idle edges must hold d.
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("hold_d", 32'(d), 32'h8000);
            check("hold_daddr", 32'(daddr), 32'h0);
            check("hold_out_valid", 32'(out_valid), 32'h0);
        end

        // Capture a result that is never checked, then reset before the
        // monitor sees it: it must be discarded.
        vr = '{16'h0298, 16'h0001, 16'h0001, 4'd0, 16'h0002, 16'h0000, 1'b0};
        drive(vr, 1'b0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_d", 32'(d), 32'h0);
        check("async_reset_daddr", 32'(daddr), 32'h0);
        check("async_reset_out_valid", 32'(out_valid), 32'h0);

        // Inputs valid while reset held: outputs must stay at 0.
        vr = '{16'h0000, 16'h0003, 16'h0004, 4'd0, 16'h0007, 16'h0000, 1'b0};
        drive(vr, 1'b0);
        @(posedge clk);
        #1;
        check("held_reset_d", 32'(d), 32'h0);
        check("held_reset_out_valid", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        #2 reset = 1'b1;

        // First capture after reset release.
        @(posedge clk);
        #1;
        drive(vr, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
